// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte enables, a post-reset clear sweep and selectable read latency.
// Optional per-byte even parity when RAM_PARITY_EN is defined.
module ram_dp_be #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
`ifdef RAM_PARITY_EN
  input  logic [DATA_WIDTH/8-1:0] par_inject,
  output logic                    parity_err,
`endif
  output logic                    busy
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 1 << ADDR_WIDTH;

  typedef enum logic {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem [Depth];
  logic                    wr_acc, rd_acc, collide;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == StInit) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == '1) state_d = StReady;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy    = (state_q == StInit);
  assign wr_acc  = wr_en && (state_q == StReady);
  assign rd_acc  = rd_en && (state_q == StReady);
  assign collide = wr_acc && (wr_addr == rd_addr) && (RDW_MODE == 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        mem[ptr_q] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first collisions take the enabled bytes straight from the write port.
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NumBytes; i++) begin
      if (collide && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
      end else begin
        s1_valid <= rd_acc;
        if (rd_acc) s1_data <= rd_word;
      end
    end
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
  end else begin : g_lat1
    assign out_valid = rd_acc;
    assign out_data  = rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= out_valid;
      if (out_valid) rd_data <= out_data;
    end
  end

`ifdef RAM_PARITY_EN
  logic [NumBytes-1:0] par_mem [Depth];
  logic [NumBytes-1:0] rd_par;
  logic                rd_perr;
  logic                perr_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        par_mem[ptr_q] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (wr_be[i]) par_mem[wr_addr][i] <= (^wr_data[8*i +: 8]) ^ par_inject[i];
        end
      end
    end
  end

  always_comb begin
    rd_par  = par_mem[rd_addr];
    rd_perr = 1'b0;
    for (int i = 0; i < NumBytes; i++) begin
      if (collide && wr_be[i]) rd_par[i] = (^wr_data[8*i +: 8]) ^ par_inject[i];
      if ((^rd_word[8*i +: 8]) != rd_par[i]) rd_perr = 1'b1;
    end
  end

  if (RD_LATENCY == 2) begin : g_perr2
    logic s1_perr;
    always_ff @(posedge clk) begin
      if (rst) s1_perr <= 1'b0;
      else if (rd_acc) s1_perr <= rd_perr;
    end
    assign perr_out = s1_perr;
  end else begin : g_perr1
    assign perr_out = rd_perr;
  end

  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= out_valid && perr_out;
  end
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// Randomised self-checking bench for ram_dp_be against an array-based reference model.
module tb_ram_dp_be;
  parameter int unsigned RD_LATENCY = 1;
  parameter int unsigned RDW_MODE   = 0;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_be = '0, par_inject = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy;
`ifdef RAM_PARITY_EN
  logic          parity_err;
`endif

  ram_dp_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LATENCY), .RDW_MODE(RDW_MODE)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
`ifdef RAM_PARITY_EN
    .par_inject(par_inject), .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word array, injected-parity flags per byte, read pipeline of RD_LATENCY.
  logic [DW-1:0] m_mem [DEPTH];
  logic [NB-1:0] m_inj [DEPTH];
  bit            m_ready = 0;
  int            m_sweep = 0;
  bit            p_valid = 0, p_perr = 0;
  logic [DW-1:0] p_data = '0;
  bit            e_valid = 0, e_perr = 0;
  logic [DW-1:0] e_data = '0;

  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [NB-1:0] be, input logic re,
                      input logic [AW-1:0] ra, input logic [NB-1:0] inj);
    bit            acc_r, acc_w, v_perr;
    logic [DW-1:0] v;
    logic [NB-1:0] vinj;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; par_inject = inj;
    @(posedge clk);
    acc_r = !r && m_ready && re;
    acc_w = !r && m_ready && we;
    v     = m_mem[ra];
    vinj  = m_inj[ra];
    if (RDW_MODE == 1 && acc_w && wa == ra) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          v[8*b +: 8] = wd[8*b +: 8];
          vinj[b]     = inj[b];
        end
      end
    end
    v_perr = |vinj;
    if (r) begin
      m_ready = 0; m_sweep = 0;
      p_valid = 0; p_data = '0; p_perr = 0;
      e_valid = 0; e_data = '0; e_perr = 0;
    end else begin
      if (RD_LATENCY == 1) begin
        e_valid = acc_r;
        if (acc_r) e_data = v;
        e_perr = acc_r && v_perr;
      end else begin
        e_valid = p_valid;
        if (p_valid) e_data = p_data;
        e_perr  = p_valid && p_perr;
        p_valid = acc_r;
        if (acc_r) begin
          p_data = v;
          p_perr = v_perr;
        end
      end
      if (acc_w) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) begin
            m_mem[wa][8*b +: 8] = wd[8*b +: 8];
            m_inj[wa][b]        = inj[b];
          end
        end
      end
      if (!m_ready) begin
        m_sweep++;
        if (m_sweep == DEPTH) begin
          m_ready = 1;
          for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
            m_inj[a] = '0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 8'h01, 32'hFFFF_FFFF, 4'hF, 1'b1, 8'h01, '0);
    n_tests++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rd_valid=%b rd_data=%h, want 1 0 0", busy, rd_valid,
               rd_data);
    end
    // Requests during the sweep must be ignored.
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), NB'($urandom), 1'b1,
           AW'($urandom), '0);
      n_tests++;
      if (busy !== (k < DEPTH) || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_edge_%0d: busy=%b rd_valid=%b, want busy=%b rd_valid=0", k, busy,
                 rd_valid, (k < DEPTH));
      end
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h00, '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'hFF, '0);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_valid !== e_valid || (e_valid && rd_data !== '0)) begin
        n_fail++;
        $display("FAIL post_sweep_read_%0d: rd_valid=%b rd_data=%h, want %b 00000000", k,
                 rd_valid, rd_data, e_valid);
      end
      idle();
    end
  endtask

  task automatic test_write_read();
    step(1'b0, 1'b1, 8'h10, 32'hA5, 4'hF, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h10, '0);
    n_tests++;
    if (rd_valid !== (RD_LATENCY == 1)) begin
      n_fail++;
      $display("FAIL latency_edge1: rd_valid=%b want %b", rd_valid, (RD_LATENCY == 1));
    end
    idle();
    n_tests++;
    if (rd_valid !== (RD_LATENCY == 2) || rd_data !== 32'hA5) begin
      n_fail++;
      $display("FAIL latency_edge2: rd_valid=%b rd_data=%h, want %b 000000a5", rd_valid,
               rd_data, (RD_LATENCY == 2));
    end
    idle();
  endtask

  task automatic test_byte_enable();
    step(1'b0, 1'b1, 8'h05, 32'h1122_3344, 4'b1111, 1'b0, '0, '0);
    step(1'b0, 1'b1, 8'h05, 32'hAABB_CCDD, 4'b0101, 1'b0, '0, '0);
    step(1'b0, 1'b1, 8'h05, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h05, '0);
    idle();
    idle();
    n_tests++;
    if (rd_data !== 32'h11BB_33DD) begin
      n_fail++;
      $display("FAIL byte_enable: rd_data=%h want 11bb33dd", rd_data);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    want = (RDW_MODE == 1) ? 32'hC3 : 32'h3C;
    step(1'b0, 1'b1, 8'h07, 32'h3C, 4'hF, 1'b0, '0, '0);
    step(1'b0, 1'b1, 8'h07, 32'hC3, 4'hF, 1'b1, 8'h07, '0);
    idle();
    idle();
    n_tests++;
    if (rd_data !== want) begin
      n_fail++;
      $display("FAIL collision_read: rd_data=%h want %h", rd_data, want);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h07, '0);
    idle();
    idle();
    n_tests++;
    if (rd_data !== 32'hC3) begin
      n_fail++;
      $display("FAIL collision_after: rd_data=%h want 000000c3", rd_data);
    end
  endtask

  task automatic test_random();
    // Narrow address range forces frequent same-address collisions with partial enables.
    for (int k = 0; k < 400; k++) begin
      logic [NB-1:0] inj;
      inj = '0;
`ifdef RAM_PARITY_EN
      inj = NB'($urandom);
`endif
      step(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
           NB'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), inj);
      n_tests++;
      if (rd_valid !== e_valid || rd_data !== e_data) begin
        n_fail++;
        $display("FAIL random_%0d: rd_valid=%b rd_data=%h, want %b %h", k, rd_valid, rd_data,
                 e_valid, e_data);
      end
`ifdef RAM_PARITY_EN
      n_tests++;
      if (parity_err !== e_perr) begin
        n_fail++;
        $display("FAIL random_parity_%0d: parity_err=%b want %b", k, parity_err, e_perr);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 20 + RD_LATENCY + 1; k++) begin
      if (k < 20) step(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'($urandom), '0);
      else idle();
      if (rd_valid === 1'b1) pulses++;
      n_tests++;
      if (rd_valid !== e_valid || rd_data !== e_data) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: rd_valid=%b rd_data=%h, want %b %h", k, rd_valid,
                 rd_data, e_valid, e_data);
      end
    end
    n_tests++;
    if (pulses != 20) begin
      n_fail++;
      $display("FAIL back_to_back_count: pulses=%0d want 20", pulses);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int fall;
    step(1'b0, 1'b1, 8'h09, 32'h55, 4'hF, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 100; k++) idle();
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    fall = -1;
    for (int k = 1; k <= 300 && fall < 0; k++) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h09, '0);
      if (busy === 1'b0) fall = k;
    end
    n_tests++;
    if (fall != DEPTH) begin
      n_fail++;
      $display("FAIL mid_sweep_busy: busy fell at edge %0d want %0d", fall, DEPTH);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h09, '0);
    idle();
    idle();
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL mid_sweep_clear: rd_data=%h want 00000000", rd_data);
    end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    step(1'b0, 1'b1, 8'h03, 32'h01, 4'hF, 1'b0, '0, 4'b0001);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h03, '0);
    if (RD_LATENCY == 2) idle();
    n_tests++;
    if (rd_valid !== 1'b1 || parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_inject: rd_valid=%b parity_err=%b want 1 1", rd_valid, parity_err);
    end
    idle();
    n_tests++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_idle: parity_err=%b want 0", parity_err);
    end
    step(1'b0, 1'b1, 8'h03, 32'h01, 4'hF, 1'b0, '0, 4'b0000);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h03, '0);
    if (RD_LATENCY == 2) idle();
    n_tests++;
    if (rd_valid !== 1'b1 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clean: rd_valid=%b parity_err=%b want 1 0", rd_valid, parity_err);
    end
    idle();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_random();
    test_back_to_back();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
Parametrised simple-dual-port synchronous RAM. It has one write port with per-byte write enables and one independent read port. Read latency is configurable, and the behaviour on a same-address read/write collision is selectable. After every reset a hardware sweep clears the whole array, and the block flags `busy` until the sweep finishes. It is the next-generation storage primitive, replacing the single-port, single-address RAM in datapath buffers.

Parameters:
- DATA_WIDTH, 8: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 8: address width. Depth = 2^ADDR_WIDTH words.
- RD_LATENCY, 1: read latency in clock edges. Legal values are 1 and 2; 2 adds an output register.
- RDW_MODE, 0: read-during-write to the same address. 0 = old data (read-first); 1 = new data (write-first, byte-merged).

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write request
- wr_addr  input  ADDR_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- wr_be  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address
- rd_data  output  DATA_WIDTH  read data
- rd_valid  output  1  one-cycle pulse per accepted read, aligned with rd_data
- busy  output  1  high while the clear sweep runs; requests are ignored while high

Behaviour:
- **Reset.** At a posedge with rst=1:
  - state goes to INIT and the clear pointer goes to 0;
  - busy=1, rd_valid=0, rd_data=0;
  - the RD_LATENCY=2 pipeline stage is cleared.
- **INIT.**
  - Each edge with rst=0 writes all-zero to mem[ptr], then increments ptr.
  - The edge that clears address 2^ADDR_WIDTH-1 moves the state to READY and sets busy=0. With defaults, busy falls at the 256th edge after rst deasserts.
  - wr_en and rd_en are ignored on every edge where busy=1 is sampled, including the final INIT edge. rd_valid stays 0.
- **Reset mid-sweep** restarts the sweep at address 0. Reset in READY re-runs the full sweep, so memory contents are never retained across reset.
- **Write (READY).** When wr_en=1 at a posedge, byte i of mem[wr_addr] is updated only where wr_be[i]=1.
  - wr_be all-zero means no change.
  - The written data is visible to reads issued on the following edge.
- **Read (READY).** A read is accepted when rd_en=1 at a posedge.
  - RD_LATENCY=1: rd_data and rd_valid are updated at that same edge.
  - RD_LATENCY=2: they are updated one edge later.
  - rd_valid is high for exactly one cycle per accepted read. Back-to-back reads give a continuous valid stream at full throughput.
  - rd_data holds its last value when no read completes.
- **Collision.** wr_en and rd_en are both accepted on the same edge with wr_addr==rd_addr.
  - RDW_MODE=0: rd_data returns the pre-write word.
  - RDW_MODE=1: rd_data returns the merged word (enabled bytes take wr_data, the other bytes keep the old data).
  - Memory is updated identically in both modes.
- **Different addresses** on the same edge do not interact.
- **Addresses** span the full 2^ADDR_WIDTH range. No out-of-range condition exists.

Optional Feature:
Macro `RAM_PARITY_EN`.

When defined:
- One even-parity bit is stored per byte.
- An extra input `par_inject` (DATA_WIDTH/8 bits) is added. On a write, the stored parity bit of each enabled byte is inverted where par_inject[i]=1.
- The INIT sweep writes parity 0, which is consistent with zero data.
- An extra output `parity_err` (1 bit) is high alongside rd_valid when any byte of the read word mismatches its stored parity. It is 0 otherwise and 0 at reset.
- In RDW_MODE=1, parity for merged bytes comes from the newly written parity.

When not defined:
- No parity storage.
- No par_inject or parity_err ports.
- All other behaviour is identical.

Test Plan:
1. Assert rst for 2 cycles, then release and hold rd_en=1 -> busy=1 for 256 edges, then 0; no rd_valid during the sweep; after busy falls, reads of addr 0x00 and 0xFF return 0x00.
2. After busy falls: write 0xA5 to addr 0x10, then read 0x10 on the next edge -> rd_data=0xA5 with rd_valid after 1 edge (RD_LATENCY=1) or 2 edges (RD_LATENCY=2).
3. With DATA_WIDTH=32: write 0x11223344 to addr 5 with be=1111, then write 0xAABBCCDD with be=0101 -> read of addr 5 returns 0x11BB33DD.
4. Preload addr 7=0x3C, then write 0xC3 to addr 7 and read addr 7 on the same edge -> rd_data=0x3C when RDW_MODE=0, 0xC3 when RDW_MODE=1; a following read returns 0xC3 in both modes.
5. Write 0x55 to addr 9, pulse rst at sweep address 100, then let the sweep complete -> busy stays high for a full 256 edges after the second release; addr 9 reads 0x00.
6. With `RAM_PARITY_EN`: write 0x01 to addr 3 with par_inject=1 -> read of addr 3 gives parity_err=1 with rd_valid; rewrite with par_inject=0 -> parity_err=0.
